// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, turns MEM-stage
// exceptions and stall-watchdog expiry into a pipeline flush with a redirect
// PC, and keeps saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040,
  parameter logic [15:0] WDOG_LIMIT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        clr_cnt,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [31:0] ExcEret = 32'h0000_000e;

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e      state_q, state_d;
  logic [15:0] wdog_cnt_q, wdog_cnt_d;

  logic [5:0]  merged;
  logic        exc;
  logic        in_run;
  logic        wdog_hit;
  logic        flush_int;

  // Stall merge, exception/watchdog decode and next-state logic.
  always_comb begin
    merged = 6'b000000;
    if (stallreq_mem) begin
      merged = 6'b011111;
    end else if (stallreq_ex) begin
      merged = 6'b001111;
    end else if (stallreq_id) begin
      merged = 6'b000111;
    end

    exc       = |excepttype_i;
    in_run    = (state_q == StRun);
    // Expiry fires on the WDOG_LIMIT-th consecutive stalled cycle; an exception wins.
    wdog_hit  = in_run && (WDOG_LIMIT != 16'd0) && (merged != 6'b000000) && !exc &&
                (wdog_cnt_q == WDOG_LIMIT - 16'd1);
    flush_int = in_run && (exc || wdog_hit);

    state_d = flush_int ? StRecover : StRun;

    if (in_run && (merged != 6'b000000) && !flush_int) begin
      wdog_cnt_d = wdog_cnt_q + 16'd1;
    end else begin
      wdog_cnt_d = 16'd0;
    end
  end

  // Combinational outputs, forced quiet while reset is asserted.
  always_comb begin
    stall    = 6'b000000;
    flush    = 1'b0;
    new_pc   = 32'h0000_0000;
    wdog_err = 1'b0;
    if (rst_n) begin
      flush    = flush_int;
      wdog_err = wdog_hit;
      if (in_run && !flush_int) begin
        stall = merged;
      end
      if (flush_int) begin
        if (exc) begin
          new_pc = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
        end else begin
          new_pc = WDOG_VECTOR;
        end
      end
    end
  end

  // FSM state and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wdog_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating performance counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else if (clr_cnt) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if ((stall != 6'b000000) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl, built with a short watchdog limit.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        clr_cnt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int checks;
  int failures;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_VECTOR(32'h0000_0040),
    .WDOG_LIMIT (16'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .clr_cnt      (clr_cnt),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .wdog_err     (wdog_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excepttype_i = 32'd0;
    cp0_epc_i    = 32'd0;
    clr_cnt      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    idle_inputs();
    stallreq_mem = 1'b1;
    excepttype_i = 32'h8;
    #1;
    checks++;
    if ({stall, flush, new_pc, wdog_err} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b flush=%b new_pc=%h wdog_err=%b, want all 0",
               stall, flush, new_pc, wdog_err);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got stall_cycles=%0d flush_count=%0d, want 0 0",
               stall_cycles, flush_count);
    end
  endtask

  task automatic test_stall_merge();
    next_cycle();
    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0) begin
        failures++;
        $display("FAIL stall_id_ex[%0d]: got stall=%b flush=%b, want 001111 0", i, stall, flush);
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL stall_release: got %b, want 000000", stall);
    end
    checks++;
    if (stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL stall_cycles_3: got %0d, want 3", stall_cycles);
    end
    // Priority: mem only, id only, mem+id; idle cycle between each.
    next_cycle();
    stallreq_mem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      failures++;
      $display("FAIL stall_mem: got %b, want 011111", stall);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      failures++;
      $display("FAIL stall_id: got %b, want 000111", stall);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    stallreq_id  = 1'b1;
    stallreq_mem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      failures++;
      $display("FAIL stall_mem_id: got %b, want 011111", stall);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_exception_stall();
    clr_cnt = 1'b1;
    next_cycle();
    clr_cnt      = 1'b0;
    stallreq_mem = 1'b1;
    excepttype_i = 32'h8;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'h20 || wdog_err !== 1'b0) begin
      failures++;
      $display("FAIL exc_flush: got flush=%b stall=%b new_pc=%h wdog_err=%b, want 1 0 20 0",
               flush, stall, new_pc, wdog_err);
    end
    next_cycle();
    #1;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b0 || new_pc !== 32'h0) begin
      failures++;
      $display("FAIL exc_recover: got flush=%b stall=%b new_pc=%h, want 0 0 0",
               flush, stall, new_pc);
    end
    next_cycle();
    excepttype_i = 32'h0;
    #1;
    checks++;
    if (stall !== 6'b011111 || flush !== 1'b0) begin
      failures++;
      $display("FAIL exc_resume: got stall=%b flush=%b, want 011111 0", stall, flush);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (flush_count !== 16'd1 || stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL exc_counters: got flush_count=%0d stall_cycles=%0d, want 1 1",
               flush_count, stall_cycles);
    end
  endtask

  task automatic test_exc_types();
    logic [31:0] types [5];
    types = '{32'h1, 32'h9, 32'ha, 32'hc, 32'hd};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      excepttype_i = types[i];
      cp0_epc_i    = 32'hdead_beef;
      #1;
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'h20) begin
        failures++;
        $display("FAIL exc_type_%0h: got flush=%b new_pc=%h, want 1 20",
                 types[i], flush, new_pc);
      end
      next_cycle();
      idle_inputs();
    end
  endtask

  task automatic test_eret();
    next_cycle();
    excepttype_i = 32'he;
    cp0_epc_i    = 32'h0000_1234;
    #1;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
      failures++;
      $display("FAIL eret: got flush=%b new_pc=%h, want 1 00001234", flush, new_pc);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      failures++;
      $display("FAIL eret_one_cycle: got flush=%b new_pc=%h, want 0 0", flush, new_pc);
    end
  endtask

  task automatic test_watchdog();
    next_cycle();
    stallreq_ex = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0 || wdog_err !== 1'b0) begin
        failures++;
        $display("FAIL wdog_stall_c%0d: got stall=%b flush=%b wdog_err=%b, want 001111 0 0",
                 c, stall, flush, wdog_err);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (flush !== 1'b1 || wdog_err !== 1'b1 || new_pc !== 32'h40 || stall !== 6'b0) begin
      failures++;
      $display("FAIL wdog_expire: got flush=%b wdog_err=%b new_pc=%h stall=%b, want 1 1 40 0",
               flush, wdog_err, new_pc, stall);
    end
    next_cycle();
    #1;
    checks++;
    if (flush !== 1'b0 || wdog_err !== 1'b0 || stall !== 6'b0) begin
      failures++;
      $display("FAIL wdog_recover: got flush=%b wdog_err=%b stall=%b, want 0 0 0",
               flush, wdog_err, stall);
    end
    next_cycle();
    #1;
    checks++;
    if (stall !== 6'b001111 || flush !== 1'b0) begin
      failures++;
      $display("FAIL wdog_resume: got stall=%b flush=%b, want 001111 0", stall, flush);
    end
    next_cycle();
    idle_inputs();
    // Two stalled cycles, one gap, then four more: expiry only on the fourth.
    next_cycle();
    stallreq_ex = 1'b1;
    next_cycle();
    next_cycle();
    stallreq_ex = 1'b0;
    next_cycle();
    stallreq_ex = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (flush !== 1'b0 || stall !== 6'b001111) begin
        failures++;
        $display("FAIL wdog_restart_c%0d: got flush=%b stall=%b, want 0 001111", c, flush, stall);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (flush !== 1'b1 || wdog_err !== 1'b1 || new_pc !== 32'h40) begin
      failures++;
      $display("FAIL wdog_restart_expire: got flush=%b wdog_err=%b new_pc=%h, want 1 1 40",
               flush, wdog_err, new_pc);
    end
    next_cycle();
    idle_inputs();
    // Exception on the would-be expiry cycle: the exception wins.
    next_cycle();
    stallreq_ex = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    excepttype_i = 32'h8;
    #1;
    checks++;
    if (flush !== 1'b1 || wdog_err !== 1'b0 || new_pc !== 32'h20 || stall !== 6'b0) begin
      failures++;
      $display("FAIL wdog_vs_exc: got flush=%b wdog_err=%b new_pc=%h stall=%b, want 1 0 20 0",
               flush, wdog_err, new_pc, stall);
    end
    next_cycle();
    excepttype_i = 32'h0;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b001111) begin
      failures++;
      $display("FAIL wdog_cleared_by_exc: got flush=%b stall=%b, want 0 001111", flush, stall);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    next_cycle();
    force dut.flush_count_q = 16'hFFFF;
    #1;
    release dut.flush_count_q;
    excepttype_i = 32'h8;
    next_cycle();
    excepttype_i = 32'h0;
    #1;
    checks++;
    if (flush_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL flush_count_sat: got %h, want ffff", flush_count);
    end
    next_cycle();
    excepttype_i = 32'h8;
    clr_cnt      = 1'b1;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (flush_count !== 16'd0 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL clr_priority: got flush_count=%0d stall_cycles=%0d, want 0 0",
               flush_count, stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    next_cycle();
    excepttype_i = 32'h8;
    next_cycle();
    stallreq_mem = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b0) begin
      failures++;
      $display("FAIL rst_pre_recover: got flush=%b stall=%b, want 0 0", flush, stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, flush, new_pc, wdog_err} !== 40'd0 || flush_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_async: got stall=%b flush=%b new_pc=%h wdog_err=%b flush_count=%0d, want 0",
               stall, flush, new_pc, wdog_err, flush_count);
    end
    next_cycle();
    stallreq_mem = 1'b0;
    rst_n        = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h20) begin
      failures++;
      $display("FAIL rst_release_exc: got flush=%b new_pc=%h, want 1 20", flush, new_pc);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL rst_release_recover: got flush=%b, want 0", flush);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stall_merge();
    test_exception_stall();
    test_exc_types();
    test_eret();
    test_watchdog();
    test_saturation();
    test_async_reset();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage OpenMIPS core. It merges stage stall requests into the six-bit `stall` vector and detects exceptions at the MEM stage. On an exception it issues the pipeline-wide `flush` and redirect PC, then runs a one-cycle recovery state. It also runs a stall watchdog and keeps saturating stall and flush performance counters. Its `stall`/`flush` outputs drive `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb`, and its `new_pc` output feeds `pc_reg`.

## Interface
- `EXC_VECTOR`, 32'h0000_0020: redirect PC for all non-ERET exceptions.
- `WDOG_VECTOR`, 32'h0000_0040: redirect PC on watchdog expiry.
- `WDOG_LIMIT`, 16'd1024: number of consecutive stalled cycles before expiry; 0 disables the watchdog.

- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stallreq_id` in 1: ID stall request (load-use hazard).
- `stallreq_ex` in 1: EX stall request (multi-cycle mul/div).
- `stallreq_mem` in 1: MEM stall request (data bus wait).
- `excepttype_i` in 32: exception type from MEM stage; nonzero means an exception.
- `cp0_epc_i` in 32: current EPC from CP0, already forwarded.
- `clr_cnt` in 1: synchronous clear of both performance counters.
- `stall` out 6: per-stage hold. Bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- `flush` out 1: clears all pipeline registers this cycle.
- `new_pc` out 32: PC loaded by `pc_reg` when `flush` = 1.
- `wdog_err` out 1: one-cycle pulse on watchdog expiry.
- `stall_cycles` out 32: saturating count of cycles with `stall` != 0.
- `flush_count` out 16: saturating count of cycles with `flush` = 1.

## Operation
- The FSM has two states, RUN and RECOVER, held in one state register. It resets to RUN.
- Stall merge in RUN with no flush. Priority is mem > ex > id:
  - `stallreq_mem` gives 6'b011111.
  - else `stallreq_ex` gives 6'b001111.
  - else `stallreq_id` gives 6'b000111.
  - else 6'b000000.
- Exception in RUN (`excepttype_i` != 0):
  - `flush` = 1 and `stall` = 0 in the same cycle.
  - Next state is RECOVER.
  - `new_pc` = `cp0_epc_i` if `excepttype_i` = 32'h0000_000e (ERET), otherwise `EXC_VECTOR`.
  - Types 0x1, 0x8, 0x9, 0xa, 0xc, 0xd all map to `EXC_VECTOR`.
- RECOVER lasts one cycle:
  - `flush` = 0 and `stall` = 0.
  - `excepttype_i` and all stall requests are ignored.
  - Next state is RUN.
- Watchdog:
  - 16-bit `wdog_cnt` increments on every RUN cycle with merged stall != 0 and no flush.
  - It clears on any cycle where merged stall = 0, on flush, and in RECOVER.
  - Expiry condition: in RUN, `WDOG_LIMIT` != 0, merged stall != 0, no exception, and `wdog_cnt` = `WDOG_LIMIT`-1.
  - On expiry: `flush` = 1, `stall` = 0, `new_pc` = `WDOG_VECTOR`, `wdog_err` = 1, and the counter clears. Next state is RECOVER.
- `new_pc` = 0 whenever `flush` = 0.
- Counters are registered:
  - `stall_cycles` adds 1 when the output `stall` != 0 and holds at 32'hFFFF_FFFF.
  - `flush_count` adds 1 when `flush` = 1 and holds at 16'hFFFF.
  - `clr_cnt` = 1 sets both to 0 next edge and takes priority over an increment in the same cycle.

## Timing
- `stall`, `flush`, `new_pc` and `wdog_err` are combinational from the current state and inputs: zero latency, asserted in the same cycle as the exception or request. `mem_wb` therefore never commits a faulting instruction.
- State, `wdog_cnt` and both counters update on the rising edge of `clk`.
- While `rst_n` = 0:
  - State = RUN, `wdog_cnt` = 0, `stall_cycles` = 0, `flush_count` = 0.
  - Outputs forced to `stall` = 0, `flush` = 0, `new_pc` = 0, `wdog_err` = 0, regardless of inputs.
- Reset takes effect asynchronously mid-operation: a RECOVER state or a partial watchdog count is discarded immediately.
- Simultaneous events:
  - Exception plus any stall request: the exception wins, and `stall` = 0.
  - Exception plus watchdog expiry: the exception wins, `wdog_err` = 0, `new_pc` follows the exception rule, and the counter clears.
  - An exception arriving in RECOVER is ignored. After a flush the pipeline holds bubbles, so none is expected there.
- Watchdog expiry occurs on exactly the `WDOG_LIMIT`-th consecutive stalled cycle. A single non-stalled cycle restarts the count.
- The flush cycle itself is not counted in `stall_cycles`.

## Test plan
- Release reset with all inputs 0. Then hold `stallreq_id` = `stallreq_ex` = 1 for 3 cycles, then all 0. Required: `stall` = 6'b001111 for 3 cycles, then 0; `stall_cycles` = 3.
- `stallreq_mem` = 1 and `excepttype_i` = 32'h8 in the same cycle. Required:
  - that cycle: `flush` = 1, `stall` = 0, `new_pc` = 32'h20;
  - next cycle: RECOVER, `flush` = 0, `stall` = 0 despite `stallreq_mem`;
  - third cycle: `stall` = 6'b011111;
  - `flush_count` = 1.
- `excepttype_i` = 32'he with `cp0_epc_i` = 32'h0000_1234. Required: `new_pc` = 32'h0000_1234 and `flush` = 1 for one cycle.
- `WDOG_LIMIT` = 4, `stallreq_ex` held high. Required:
  - `stall` = 6'b001111 for cycles 1-3;
  - cycle 4: `flush` = 1, `wdog_err` = 1, `new_pc` = 32'h40;
  - cycle 5: RECOVER;
  - cycle 6: stall resumes.
  - Repeat with `stallreq_ex` dropped for one cycle after cycle 2: no expiry until 4 further stalled cycles.
- Preload `flush_count` to 16'hFFFF by forcing, or by running 65535 flushes, then flush again: it stays 16'hFFFF. Assert `clr_cnt` together with an increment: both counters read 0 next cycle.
- Deassert `rst_n` asynchronously while in RECOVER with `excepttype_i` nonzero. Required: all outputs 0 immediately; after release, the first cycle is RUN and handles the exception normally.
